// File: rtl/uart_step_bridge_pkg.sv
// Shared definitions for the UART single-step debug bridge: FSM state encoding
// and the UART byte width.
package uart_step_bridge_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_RECV,
    ST_STEP_LO,
    ST_STEP_HI,
    ST_CAPTURE,
    ST_SEND,
    ST_GUARD,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/uart_step_tx_seq.sv
// Response byte sequencer: shifts a captured response out LSB-first over the UART TX handshake.
// Optional trailing XOR checksum byte when UART_STEP_BRIDGE_CHECKSUM_EN is defined.
module uart_step_tx_seq
  import uart_step_bridge_pkg::*;
#(
  parameter int RESP_BYTES = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_load,
  input  logic [BYTE_W*RESP_BYTES-1:0] i_resp,
  input  logic                         i_tx_busy,
  output logic [BYTE_W-1:0]            o_tx_buf,
  output logic                         o_tx_start,
  output logic                         o_done
);

`ifdef UART_STEP_BRIDGE_CHECKSUM_EN
  localparam int NBYTES = RESP_BYTES + 1;
`else
  localparam int NBYTES = RESP_BYTES;
`endif
  localparam int SW = BYTE_W * NBYTES;
  localparam int CW = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] LAST_RIDX = CW'(NBYTES - 1);

  state_t          r_state;
  logic [SW-1:0]   r_shift;
  logic [CW-1:0]   r_ridx;
  logic [SW-1:0]   w_load_val;
  logic            w_last;

`ifdef UART_STEP_BRIDGE_CHECKSUM_EN
  logic [BYTE_W-1:0] w_csum;

  always_comb begin
    w_csum = '0;
    for (int b = 0; b < RESP_BYTES; b++) w_csum = w_csum ^ i_resp[b*BYTE_W +: BYTE_W];
  end

  // Checksum rides as the most significant byte so it leaves last.
  assign w_load_val = {w_csum, i_resp};
`else
  assign w_load_val = i_resp;
`endif

  assign w_last = (r_ridx == LAST_RIDX);
  assign o_done = (r_state == ST_DRAIN) && !i_tx_busy && w_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_RECV;
      r_shift    <= '0;
      r_ridx     <= '0;
      o_tx_buf   <= '0;
      o_tx_start <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      case (r_state)
        ST_RECV: begin
          if (i_load) begin
            r_shift <= w_load_val;
            r_ridx  <= '0;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!i_tx_busy) begin
            o_tx_buf   <= r_shift[BYTE_W-1:0];
            o_tx_start <= 1'b1;
            r_state    <= ST_GUARD;
          end
        end
        // The UART raises busy a cycle late; skip one sample before trusting it.
        ST_GUARD: r_state <= ST_DRAIN;
        ST_DRAIN: begin
          if (!i_tx_busy) begin
            if (w_last) begin
              r_state <= ST_RECV;
            end else begin
              r_ridx  <= r_ridx + 1'b1;
              r_shift <= r_shift >> BYTE_W;
              r_state <= ST_SEND;
            end
          end
        end
        default: r_state <= ST_RECV;
      endcase
    end
  end

endmodule

// File: rtl/uart_step_bridge.sv
// UART single-step debug bridge: assembles a command word, pulses step_clk once,
// and returns the response. Optional checksum byte via UART_STEP_BRIDGE_CHECKSUM_EN.
module uart_step_bridge
  import uart_step_bridge_pkg::*;
#(
  parameter int WORD_BYTES      = 4,
  parameter int RESP_BYTES      = 1,
  parameter int STEP_LOW_CYCLES = 1,
  parameter int TIMEOUT_CYCLES  = 0
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         RXready,
  input  logic [BYTE_W-1:0]            RXbuffer,
  input  logic                         TXbusy,
  output logic [BYTE_W-1:0]            TXbuffer,
  output logic                         TXstart,
  output logic [BYTE_W*WORD_BYTES-1:0] word_out,
  output logic                         word_valid,
  output logic                         step_clk,
  input  logic [BYTE_W*RESP_BYTES-1:0] resp_in,
  output logic                         busy,
  output logic                         rx_overrun
);

  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int LW = $clog2(STEP_LOW_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORD_BYTES - 1);
  localparam logic [LW-1:0] LO_LAST  = LW'(STEP_LOW_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST   = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic [LW-1:0] r_lcnt;
  logic [TW-1:0] r_tcnt;
  logic          w_load;
  logic          w_done;

  assign busy   = (r_state != ST_RECV);
  // Response is sampled on the edge after step_clk rises, giving the target a full cycle.
  assign w_load = (r_state == ST_STEP_HI);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= ST_RECV;
      r_idx      <= '0;
      r_lcnt     <= '0;
      r_tcnt     <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      step_clk   <= 1'b1;
      rx_overrun <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (RXready && (r_state != ST_RECV)) rx_overrun <= 1'b1;
      case (r_state)
        ST_RECV: begin
          if (RXready) begin
            for (int b = 0; b < WORD_BYTES; b++)
              if (r_idx == IW'(b)) word_out[b*BYTE_W +: BYTE_W] <= RXbuffer;
            r_tcnt <= '0;
            if (r_idx == LAST_IDX) begin
              r_idx      <= '0;
              word_valid <= 1'b1;
              step_clk   <= 1'b0;
              r_lcnt     <= '0;
              r_state    <= ST_STEP_LO;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else if ((TIMEOUT_CYCLES > 0) && (r_idx != '0)) begin
            // Abandon a stalled partial word; bytes already written stay stale.
            if (r_tcnt == T_LAST) begin
              r_idx  <= '0;
              r_tcnt <= '0;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end else begin
            r_tcnt <= '0;
          end
        end
        ST_STEP_LO: begin
          if (r_lcnt == LO_LAST) begin
            step_clk <= 1'b1;
            r_state  <= ST_STEP_HI;
          end else begin
            r_lcnt <= r_lcnt + 1'b1;
          end
        end
        ST_STEP_HI: r_state <= ST_CAPTURE;
        ST_CAPTURE: r_state <= ST_SEND;
        ST_SEND:    if (w_done) r_state <= ST_RECV;
        default:    r_state <= ST_RECV;
      endcase
    end
  end

  uart_step_tx_seq #(
    .RESP_BYTES(RESP_BYTES)
  ) u_tx_seq (
    .i_clk      (CLK),
    .i_rst_n    (RESET_N),
    .i_load     (w_load),
    .i_resp     (resp_in),
    .i_tx_busy  (TXbusy),
    .o_tx_buf   (TXbuffer),
    .o_tx_start (TXstart),
    .o_done     (w_done)
  );

endmodule

// File: tb/tb_uart_step_bridge.sv
// Self-checking bench for uart_step_bridge (4-byte words, 2-byte responses,
// 3-cycle step low, 20-cycle timeout) with a behavioural UART TX model.
module tb_uart_step_bridge;

  localparam int WB = 4;
  localparam int RB = 2;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          RXready = 1'b0;
  logic [7:0]    RXbuffer = 8'h00;
  logic          TXbusy;
  logic [7:0]    TXbuffer;
  logic          TXstart;
  logic [8*WB-1:0] word_out;
  logic          word_valid;
  logic          step_clk;
  logic [8*RB-1:0] resp_in = '0;
  logic          busy;
  logic          rx_overrun;

  int n_vec = 0;
  int n_err = 0;

  uart_step_bridge #(
    .WORD_BYTES(WB), .RESP_BYTES(RB), .STEP_LOW_CYCLES(3), .TIMEOUT_CYCLES(20)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .RXready(RXready), .RXbuffer(RXbuffer),
    .TXbusy(TXbusy), .TXbuffer(TXbuffer), .TXstart(TXstart),
    .word_out(word_out), .word_valid(word_valid), .step_clk(step_clk),
    .resp_in(resp_in), .busy(busy), .rx_overrun(rx_overrun)
  );

  always #5 CLK = ~CLK;

  // UART transmitter model: busy for 10 cycles after each accepted start.
  int busy_cnt = 0;
  int viol = 0;
  int wv_cnt = 0;
  logic [7:0] got_q[$];
  assign TXbusy = (busy_cnt != 0);

  always @(negedge CLK) begin
    if (word_valid === 1'b1) wv_cnt++;
    if (TXstart === 1'b1) begin
      if (busy_cnt != 0) viol++;
      got_q.push_back(TXbuffer);
      busy_cnt = 10;
    end else if (busy_cnt != 0) begin
      busy_cnt--;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK); RXbuffer = b; RXready = 1'b1;
    @(negedge CLK); RXready = 1'b0;
  endtask

  task automatic send_word(input logic [8*WB-1:0] w, input int max_gap);
    for (int i = 0; i < WB; i++) begin
      send_byte(w[8*i +: 8]);
      if (i < WB - 1) repeat ($urandom_range(0, max_gap)) @(negedge CLK);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 1000) begin @(negedge CLK); n++; end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL %s_idle: busy=%b after %0d cycles, want 0", name, busy, n);
    end
  endtask

  // Reference: response bytes LSB-first, optionally followed by their XOR.
  task automatic check_tx(input string name, input logic [8*RB-1:0] r);
    logic [7:0] exp_q[$];
    logic [7:0] x;
    bit bad;
    x = 8'h00;
    for (int i = 0; i < RB; i++) begin exp_q.push_back(r[8*i +: 8]); x ^= r[8*i +: 8]; end
`ifdef UART_STEP_BRIDGE_CHECKSUM_EN
    exp_q.push_back(x);
`endif
    bad = (got_q.size() != exp_q.size());
    if (!bad) for (int i = 0; i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad = 1'b1;
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL %s_tx: got %0d bytes first=%h, want %0d bytes first=%h", name,
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q.size(), exp_q[0]);
    end
    got_q.delete();
  endtask

  task automatic check_word(input string name, input logic [8*WB-1:0] exp_w, input int exp_wv);
    n_vec++;
    if (word_out !== exp_w) begin
      n_err++; $display("FAIL %s_word: got %h, want %h", name, word_out, exp_w);
    end
    n_vec++;
    if (wv_cnt !== exp_wv) begin
      n_err++; $display("FAIL %s_wvcount: got %0d, want %0d", name, wv_cnt, exp_wv);
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    n_vec++; if (step_clk !== 1'b1) begin n_err++; $display("FAIL rst_step_clk: got %b, want 1", step_clk); end
    n_vec++; if (TXstart !== 1'b0) begin n_err++; $display("FAIL rst_txstart: got %b, want 0", TXstart); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, want 0", busy); end
    n_vec++; if (word_out !== '0) begin n_err++; $display("FAIL rst_word: got %h, want 0", word_out); end
    n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL rst_wv: got %b, want 0", word_valid); end
    n_vec++; if (rx_overrun !== 1'b0) begin n_err++; $display("FAIL rst_ovr: got %b, want 0", rx_overrun); end
    n_vec++; if (TXbuffer !== 8'h00) begin n_err++; $display("FAIL rst_txbuf: got %h, want 00", TXbuffer); end
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_basic_step();
    int low = 1;
    int guard = 0;
    int wv0 = wv_cnt;
    resp_in = 16'hBEEF;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    @(negedge CLK); RXbuffer = 8'h44; RXready = 1'b1;
    @(negedge CLK); RXready = 1'b0;
    n_vec++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL basic_wv_pulse: got %b, want 1", word_valid); end
    n_vec++; if (step_clk !== 1'b0) begin n_err++; $display("FAIL basic_step_fall: got %b, want 0", step_clk); end
    @(negedge CLK);
    while (step_clk === 1'b0 && guard < 20) begin low++; guard++; @(negedge CLK); end
    n_vec++; if (low != 3) begin n_err++; $display("FAIL basic_step_low: got %0d cycles, want 3", low); end
    @(negedge CLK);
    n_vec++; if (TXstart !== 1'b0) begin n_err++; $display("FAIL basic_tx_early: got %b, want 0", TXstart); end
    @(negedge CLK);
    n_vec++; if (TXstart !== 1'b1 || TXbuffer !== 8'hEF) begin
      n_err++; $display("FAIL basic_tx_latency: got start=%b buf=%h, want 1/ef", TXstart, TXbuffer);
    end
    wait_idle("basic");
    check_word("basic", 32'h44332211, wv0 + 1);
    check_tx("basic", 16'hBEEF);
  endtask

  task automatic test_random_words();
    for (int k = 0; k < 5; k++) begin
      logic [8*WB-1:0] w;
      int wv0;
      w = {$urandom()};
      wv0 = wv_cnt;
      resp_in = 16'($urandom());
      send_word(w, 10);
      wait_idle("rand");
      check_word("rand", w, wv0 + 1);
      check_tx("rand", resp_in);
    end
  endtask

  task automatic test_overrun();
    logic [8*WB-1:0] w1, w2;
    int n = 0;
    int wv0 = wv_cnt;
    w1 = {$urandom()};
    w2 = {$urandom()};
    resp_in = 16'($urandom());
    n_vec++; if (rx_overrun !== 1'b0) begin n_err++; $display("FAIL ovr_pre: got %b, want 0", rx_overrun); end
    send_word(w1, 0);
    while (TXstart !== 1'b1 && n < 100) begin @(negedge CLK); n++; end
    n_vec++; if (TXstart !== 1'b1) begin n_err++; $display("FAIL ovr_txwait: got %b, want 1", TXstart); end
    send_byte(8'h55);
    n_vec++; if (rx_overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b, want 1", rx_overrun); end
    wait_idle("ovr1");
    check_word("ovr1", w1, wv0 + 1);
    check_tx("ovr1", resp_in);
    resp_in = 16'($urandom());
    send_word(w2, 3);
    wait_idle("ovr2");
    check_word("ovr2", w2, wv0 + 2);
    check_tx("ovr2", resp_in);
    n_vec++; if (rx_overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b, want 1", rx_overrun); end
  endtask

  // A partial word is abandoned once 20 idle cycles pass with no byte.
  task automatic test_timeout();
    logic [8*WB-1:0] w;
    logic [7:0] b0;
    int wv0;
    wv0 = wv_cnt;
    resp_in = 16'($urandom());
    send_byte(8'hAA);
    repeat (25) @(negedge CLK);
    send_word(32'h04030201, 0);
    wait_idle("to_plan");
    check_word("to_plan", 32'h04030201, wv0 + 1);
    check_tx("to_plan", resp_in);

    w = {$urandom()}; b0 = w[7:0];
    resp_in = 16'($urandom());
    send_byte(b0);
    repeat (18) @(negedge CLK);
    for (int i = 1; i < WB; i++) send_byte(w[8*i +: 8]);
    wait_idle("to_keep");
    check_word("to_keep", w, wv0 + 2);
    check_tx("to_keep", resp_in);

    b0 = 8'($urandom());
    w = {$urandom()};
    resp_in = 16'($urandom());
    send_byte(b0);
    repeat (19) @(negedge CLK);
    send_word(w, 0);
    wait_idle("to_drop");
    check_word("to_drop", w, wv0 + 3);
    check_tx("to_drop", resp_in);
  endtask

  task automatic test_reset_mid_step();
    logic [8*WB-1:0] w;
    int wv0;
    w = {$urandom()};
    resp_in = 16'($urandom());
    for (int i = 0; i < WB - 1; i++) send_byte(w[8*i +: 8]);
    @(negedge CLK); RXbuffer = w[8*(WB-1) +: 8]; RXready = 1'b1;
    @(negedge CLK); RXready = 1'b0;
    @(negedge CLK);
    n_vec++; if (step_clk !== 1'b0) begin n_err++; $display("FAIL mid_low2: got %b, want 0", step_clk); end
    RESET_N = 1'b0;
    #1;
    n_vec++; if (step_clk !== 1'b1) begin n_err++; $display("FAIL mid_step_clk: got %b, want 1", step_clk); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b, want 0", busy); end
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (40) @(negedge CLK);
    n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL mid_no_tx: got %0d bytes, want 0", got_q.size()); end
    n_vec++; if (rx_overrun !== 1'b0 || word_out !== '0) begin
      n_err++; $display("FAIL mid_cleared: got ovr=%b word=%h, want 0/0", rx_overrun, word_out);
    end
    got_q.delete();
    wv0 = wv_cnt;
    w = {$urandom()};
    resp_in = 16'($urandom());
    send_word(w, 5);
    wait_idle("mid_recover");
    check_word("mid_recover", w, wv0 + 1);
    check_tx("mid_recover", resp_in);
  endtask

  initial begin
    test_reset();
    test_basic_step();
    test_random_words();
    test_overrun();
    test_timeout();
    test_reset_mid_step();
    n_vec++;
    if (viol != 0) begin n_err++; $display("FAIL tx_while_busy: got %0d starts, want 0", viol); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
